dfd_pixel_stream_source: RTL

- Transmit end of the raster pixel interface consumed by the DFD scale pipelines: rho_plus/rho_minus uint8 pair plus col/row/valid.
- Accepts paired uint8 pixels from a ready/valid upstream, such as a DMA or camera bridge.
- Emits them in raster order with generated col/row coordinates.
- Inserts programmable horizontal and vertical blanking so downstream window fetchers and line buffers drain between rows and frames.

---
 rtl/dfd_pixel_stream_source.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dfd_pixel_stream_source.sv
// rtl/dfd_pixel_stream_source.sv - raster pixel source with generated col/row and h/v blanking
// Optional s_last_i consistency check with resync is enabled by DFD_PIXEL_SOURCE_LAST_CHECK_EN.
module dfd_pixel_stream_source #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int H_BLANK      = 0,
  parameter int V_BLANK      = 16,
  parameter int BLANK_WIDTH  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [15:0] s_data_i,
  input  logic        s_valid_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  output logic [7:0]  i_rho_plus_uint8_o,
  output logic [7:0]  i_rho_minus_uint8_o,
  output logic [15:0] col_o,
  output logic [15:0] row_o,
  output logic        valid_o,
  output logic        frame_done_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [15:0] COL_LAST = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMAGE_HEIGHT - 1);
  localparam logic [BLANK_WIDTH-1:0] H_LAST = BLANK_WIDTH'(H_BLANK - 1);
  localparam logic [BLANK_WIDTH-1:0] V_LAST = BLANK_WIDTH'(V_BLANK - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [15:0]            col;
  logic [15:0]            row;
  logic [BLANK_WIDTH-1:0] blank_cnt;
  logic                   accept;
  logic                   row_end;
  logic                   frame_end;
  logic                   early_last;

  assign s_ready_o = (state == ACTIVE);
  assign busy_o    = (state != IDLE);
  assign accept    = s_ready_o && s_valid_i;
  assign row_end   = (col == COL_LAST);
  assign frame_end = row_end && (row == ROW_LAST);

`ifdef DFD_PIXEL_SOURCE_LAST_CHECK_EN
  // An early end-of-frame marker ends the frame on that beat so the source realigns to upstream.
  assign early_last = s_last_i && !frame_end;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_o <= 1'b0;
    end else if (accept && (s_last_i != frame_end)) begin
      err_o <= 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = s_last_i;
  assign early_last  = 1'b0;
  assign err_o       = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable_i) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (accept) begin
          if (frame_end || early_last) begin
            state_nxt = (V_BLANK > 0) ? VBLANK : IDLE;
          end else if (row_end && (H_BLANK > 0)) begin
            state_nxt = HBLANK;
          end
        end
      end
      HBLANK: begin
        if (blank_cnt == H_LAST) state_nxt = ACTIVE;
      end
      VBLANK: begin
        if (blank_cnt == V_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data/coordinates only load on an accepted beat, so they hold through gaps and blanking.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      col                 <= '0;
      row                 <= '0;
      blank_cnt           <= '0;
      valid_o             <= 1'b0;
      frame_done_o        <= 1'b0;
      col_o               <= '0;
      row_o               <= '0;
      i_rho_plus_uint8_o  <= '0;
      i_rho_minus_uint8_o <= '0;
    end else begin
      valid_o      <= 1'b0;
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i) begin
            col       <= '0;
            row       <= '0;
            blank_cnt <= '0;
          end
        end
        ACTIVE: begin
          blank_cnt <= '0;
          if (accept) begin
            valid_o             <= 1'b1;
            frame_done_o        <= frame_end;
            col_o               <= col;
            row_o               <= row;
            i_rho_plus_uint8_o  <= s_data_i[15:8];
            i_rho_minus_uint8_o <= s_data_i[7:0];
            if (frame_end || early_last) begin
              col <= '0;
              row <= '0;
            end else if (row_end) begin
              col <= '0;
              row <= row + 16'd1;
            end else begin
              col <= col + 16'd1;
            end
          end
        end
        HBLANK, VBLANK: begin
          blank_cnt <= blank_cnt + 1'b1;
        end
        default: begin
          blank_cnt <= '0;
        end
      endcase
    end
  end

endmodule
